neuron_layer_sched: RTL and testbench
=====================================

# neuron_layer_sched

Layer scheduler that time-multiplexes one serial fixed-point MAC across the M neurons of a fully-connected layer. It accepts one N-element input vector through a valid/ready handshake and fetches each neuron's weights and bias from external synchronous ROMs. For every neuron it accumulates N products serially, adds the bias, applies ReLU and saturation, and streams the M results out through a second valid/ready handshake. It sits between the input-vector source and the next layer, and replaces M parallel neuron instances.

## Interface
- N, 2, inputs per neuron
- M, 4, neurons per layer
- QM, 6, input/bias/output integer bits (signed, includes sign)
- QN, 10, input/bias/output fraction bits
- WM, 6, weight integer bits (signed)
- WN, 10, weight fraction bits
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input vector valid
- in_ready  out  1  scheduler can accept a vector
- in_data  in  N x (QM+QN), signed  input vector, element i = x[i]
- w_addr  out  clog2(M*N)  weight ROM address, m*N+i
- w_data  in  WM+WN, signed  weight, valid 1 cycle after w_addr
- b_addr  out  clog2(M)  bias ROM address, = current neuron m
- b_data  in  QM+QN, signed  bias, valid 1 cycle after b_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  QM+QN, signed  neuron result, always >= 0
- out_idx  out  clog2(M)  neuron index of out_data
- out_last  out  1  high with out_valid for neuron M-1
- busy  out  1  high whenever the state is not IDLE

## Operation
- FSM states: IDLE, MAC, FINISH, EMIT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: register in_data, set m=0, clear the accumulator, go to MAC.
- MAC (N+1 cycles, sub-counter j=0..N):
  - For j<N: w_addr=m*N+j.
  - For j>=1: acc += x[j-1]*w_data.
  - b_addr=m throughout.
  - After j=N: go to FINISH.
- FINISH (1 cycle), computes and registers the result:
  - s = acc + (b_data <<< WN).
  - r = s >>> WN (arithmetic shift, truncation toward -inf).
  - If r<0, r=0 (ReLU).
  - If r > 2^(QM+QN-1)-1, r saturates to that value.
  - Register r into out_data, set out_idx=m and out_last=(m==M-1), then go to EMIT.
- EMIT:
  - out_valid=1; out_data, out_idx and out_last are held stable.
  - On out_ready: if m==M-1 go to IDLE, else set m=m+1, clear the accumulator, go to MAC.
- Arithmetic widths:
  - Product: QM+QN+WM+WN bits, fraction QN+WN.
  - Accumulator: QM+QN+WM+WN+clog2(N)+1 bits, so it cannot overflow.
- in_valid outside IDLE is ignored (in_ready=0). The registered vector is never modified mid-layer.
- Reset (rst_n=0 at a posedge) from any state:
  - Next state IDLE, m=0, accumulator cleared.
  - out_valid=0, out_data=0, out_idx=0, out_last=0.
  - w_addr=0, b_addr=0, busy=0, in_ready=1.
  - A partial layer is discarded and no result is emitted for it.

## Timing
- All outputs are registered. in_ready and busy decode the registered state.
- The capture edge is cycle 0. MAC occupies cycles 1..N+1, FINISH cycle N+2, and out_valid first rises in cycle N+3.
- With out_ready held high:
  - One neuron every N+3 cycles.
  - A full layer takes M*(N+3) cycles from capture to the last handshake.
  - in_ready rises the cycle after the out_last handshake.
- Backpressure: EMIT stalls indefinitely. No ROM addresses advance while stalled, and the outputs hold.
- There is no overlap between layers. A new vector is accepted only in IDLE.

## Structure
- Shared package nn_sched_pkg:
  - State enum (IDLE, MAC, FINISH, EMIT).
  - Width localparam functions for the product and accumulator.
  - The saturate/ReLU function, reusable by other neuron blocks.
- Sub-module serial_mac_unit:
  - Signed multiplier plus accumulator with clear/enable.
  - Parameterised by QM, QN, WM, WN, N.
- The FSM, counters and output registers live in the top.

## Test plan
In all scenarios N=2, M=4, QN=WN=10, so 1.0 = 1024.
1. Reset: hold rst_n=0 for 2 cycles -> all outputs are 0 except in_ready=1; busy=0.
2. Nominal: x=[1024,2048], all weights 1024, all biases 512 -> four results of 3584 with out_idx 0..3 and out_last only on idx 3. The first out_valid comes 5 cycles after capture, then one result every 5 cycles.
3. ReLU and truncation:
   - x=[1024,1024], w=[-2048,512], bias 0 -> 0.
   - x=[1],[0], w=[-1],[0], bias 0 -> 0 (truncation toward -inf, then clamp).
4. Saturation: x=[31744,31744] (31.0), w=[31744,31744], bias 0 -> out_data=32767.
5. Backpressure: drop out_ready for 10 cycles on neuron 1 -> out_data, out_idx, w_addr and b_addr all stable. Neurons 2 and 3 then follow correctly, and in_valid pulses during the stall are ignored.
6. Reset mid-layer: assert rst_n=0 during the MAC of neuron 2 -> IDLE next cycle, with no out_valid for neurons 2 or 3. The next vector produces the correct results starting from out_idx=0.

Source files
------------

// File: rtl/nn_sched_pkg.sv
// Shared types and arithmetic helpers for the serial neuron-layer scheduler
// and any other fixed-point neuron blocks built on the same MAC datapath.
package nn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    FINISH = 2'd2,
    EMIT   = 2'd3
  } sched_state_e;

  function automatic int prod_w(input int qm, input int qn, input int wm, input int wn);
    return qm + qn + wm + wn;
  endfunction

  // One guard bit beyond clog2(n) keeps a sum of n full-scale products from wrapping.
  function automatic int acc_w(input int qm, input int qn, input int wm, input int wn,
                               input int n);
    return prod_w(qm, qn, wm, wn) + $clog2(n) + 1;
  endfunction

  // Drops frac bits (floor), clamps negatives to zero and large values to the
  // largest positive out_w-bit two's-complement number.
  function automatic logic [63:0] relu_sat(input logic signed [63:0] s, input int frac,
                                           input int out_w);
    logic signed [63:0] r;
    logic signed [63:0] max_v;
    r     = s >>> frac;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    if (r < 64'sd0) begin
      relu_sat = 64'd0;
    end else if (r > max_v) begin
      relu_sat = max_v;
    end else begin
      relu_sat = r;
    end
  endfunction

endpackage

// File: rtl/serial_mac_unit.sv
// Serial signed multiply-accumulate: one x*w product per enabled cycle,
// accumulated at full precision into a non-overflowing register.
module serial_mac_unit
  import nn_sched_pkg::*;
#(
  parameter int QM = 6,
  parameter int QN = 10,
  parameter int WM = 6,
  parameter int WN = 10,
  parameter int N  = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr,
  input  logic                                 en,
  input  logic [QM+QN-1:0]                     x,
  input  logic [WM+WN-1:0]                     w,
  output logic [acc_w(QM, QN, WM, WN, N)-1:0]  acc
);

  localparam int D     = QM + QN;
  localparam int W     = WM + WN;
  localparam int P     = prod_w(QM, QN, WM, WN);
  localparam int ACC_W = acc_w(QM, QN, WM, WN, N);

  logic [P-1:0]     x_ext_s;
  logic [P-1:0]     w_ext_s;
  logic [P-1:0]     prod_s;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  // Sign-extending both operands to the product width makes the low P bits
  // of an unsigned multiply equal to the signed product.
  assign x_ext_s = {{(P - D){x[D-1]}}, x};
  assign w_ext_s = {{(P - W){w[W-1]}}, w};
  assign prod_s  = x_ext_s * w_ext_s;

  // Next accumulator value: clear wins over accumulate.
  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = ACC_W'(0);
    end else if (en) begin
      acc_d = acc_q + {{(ACC_W - P){prod_s[P-1]}}, prod_s};
    end else begin
      acc_d = acc_q;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= ACC_W'(0);
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/neuron_layer_sched.sv
// Fully-connected layer scheduler: runs M neurons of N inputs each through one
// serial MAC, fetching weights/biases from synchronous ROMs, streaming ReLU results.
module neuron_layer_sched
  import nn_sched_pkg::*;
#(
  parameter int N  = 2,
  parameter int M  = 4,
  parameter int QM = 6,
  parameter int QN = 10,
  parameter int WM = 6,
  parameter int WN = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*(QM+QN)-1:0]     in_data,
  output logic [$clog2(M*N)-1:0]   w_addr,
  input  logic [WM+WN-1:0]         w_data,
  output logic [$clog2(M)-1:0]     b_addr,
  input  logic [QM+QN-1:0]         b_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [QM+QN-1:0]         out_data,
  output logic [$clog2(M)-1:0]     out_idx,
  output logic                     out_last,
  output logic                     busy
);

  localparam int D     = QM + QN;
  localparam int ACC_W = acc_w(QM, QN, WM, WN, N);
  localparam int MW    = $clog2(M);
  localparam int AW    = $clog2(M * N);
  localparam int JW    = $clog2(N + 1);
  localparam int XW    = (N > 1) ? $clog2(N) : 1;

  localparam logic [MW-1:0] M_LAST = MW'(M - 1);
  localparam logic [JW-1:0] J_LAST = JW'(N);
  localparam logic [JW-1:0] J_WEND = JW'(N - 1);

  sched_state_e          state_d, state_q;
  logic [MW-1:0]         m_d, m_q;
  logic [JW-1:0]         j_d, j_q;
  logic [N-1:0][D-1:0]   x_d, x_q;
  logic [AW-1:0]         w_addr_d, w_addr_q;
  logic                  out_valid_d, out_valid_q;
  logic [D-1:0]          out_data_d, out_data_q;
  logic [MW-1:0]         out_idx_d, out_idx_q;
  logic                  out_last_d, out_last_q;
  logic                  in_ready_d, in_ready_q;
  logic                  busy_d, busy_q;

  logic                  acc_clr_s;
  logic                  acc_en_s;
  logic [XW-1:0]         x_idx_s;
  logic [D-1:0]          x_sel_s;
  logic [ACC_W-1:0]      acc_s;
  logic signed [63:0]    acc_ext_s;
  logic signed [63:0]    bias_ext_s;
  logic signed [63:0]    sum_s;

  // Weight for element j arrives in sub-cycle j+1, so pair it with x[j-1] there.
  assign x_idx_s = (j_q == JW'(0)) ? XW'(0) : XW'(j_q - JW'(1));
  assign x_sel_s = x_q[x_idx_s];

  serial_mac_unit #(
    .QM (QM),
    .QN (QN),
    .WM (WM),
    .WN (WN),
    .N  (N)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr_s),
    .en    (acc_en_s),
    .x     (x_sel_s),
    .w     (w_data),
    .acc   (acc_s)
  );

  // Bias is aligned to the product fraction (QN+WN) before the final rescale.
  assign acc_ext_s  = {{(64 - ACC_W){acc_s[ACC_W-1]}}, acc_s};
  assign bias_ext_s = {{(64 - D){b_data[D-1]}}, b_data};
  assign sum_s      = acc_ext_s + (bias_ext_s <<< WN);

  // Next-state and next-output logic for the layer FSM.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    j_d         = j_q;
    x_d         = x_q;
    w_addr_d    = w_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    acc_clr_s   = 1'b0;
    acc_en_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          x_d       = in_data;
          m_d       = MW'(0);
          j_d       = JW'(0);
          w_addr_d  = AW'(0);
          acc_clr_s = 1'b1;
          state_d   = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_en_s = (j_q != JW'(0));
        if (j_q < J_WEND) begin
          w_addr_d = w_addr_q + AW'(1);
        end else begin
          w_addr_d = w_addr_q;
        end
        if (j_q == J_LAST) begin
          j_d     = JW'(0);
          state_d = FINISH;
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      FINISH: begin
        out_data_d  = D'(relu_sat(sum_s, WN, D));
        out_idx_d   = m_q;
        out_last_d  = (m_q == M_LAST);
        out_valid_d = 1'b1;
        state_d     = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (m_q == M_LAST) begin
            state_d = IDLE;
          end else begin
            // w_addr sits on m*N+N-1 here, so +1 lands on the next neuron's first weight.
            m_d       = m_q + MW'(1);
            j_d       = JW'(0);
            w_addr_d  = w_addr_q + AW'(1);
            acc_clr_s = 1'b1;
            state_d   = MAC;
          end
        end else begin
          state_d = EMIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  // State, counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= MW'(0);
      j_q         <= JW'(0);
      x_q         <= '{default: D'(0)};
      w_addr_q    <= AW'(0);
      out_valid_q <= 1'b0;
      out_data_q  <= D'(0);
      out_idx_q   <= MW'(0);
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      j_q         <= j_d;
      x_q         <= x_d;
      w_addr_q    <= w_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign w_addr    = w_addr_q;
  assign b_addr    = m_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_neuron_layer_sched.sv
// Scoreboard bench for neuron_layer_sched (N=2, M=4, Q6.10): behavioural ROMs,
// a reference model pushing expected results at capture, and a handshake monitor.
module tb_neuron_layer_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [2:0]  w_addr;
  logic [15:0] w_data;
  logic [1:0]  b_addr;
  logic [15:0] b_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic        busy;

  logic signed [15:0] wrom [8];
  logic signed [15:0] brom [4];

  typedef struct {
    logic [15:0] data;
    logic [1:0]  idx;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   hs_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   cap_cyc = 0;

  neuron_layer_sched #(
    .N(2), .M(4), .QM(6), .QN(10), .WM(6), .WN(10)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .w_addr    (w_addr),
    .w_data    (w_data),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    w_data <= wrom[w_addr];
    b_data <= brom[b_addr];
  end

  // Output handshake monitor: records handshake edge and checks against the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      hs_q.push_back(cyc + 1);
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_underflow: got idx %0d data %0d, expected no result", out_idx, out_data);
      end else begin
        mon_e = sb.pop_front();
        if (out_data !== mon_e.data || out_idx !== mon_e.idx || out_last !== mon_e.last) begin
          miscompares++;
          $display("FAIL result: got data %0d idx %0d last %0b, expected data %0d idx %0d last %0b",
                   out_data, out_idx, out_last, mon_e.data, mon_e.idx, mon_e.last);
        end
      end
    end
  end

  function automatic logic [15:0] model(input int m, input int x0, input int x1);
    longint s;
    longint r;
    s = longint'(x0) * longint'(wrom[m*2]) + longint'(x1) * longint'(wrom[m*2+1])
        + longint'(brom[m]) * 1024;
    r = s >>> 10;
    if (r < 0) r = 0;
    else if (r > 32767) r = 32767;
    return r[15:0];
  endfunction

  task automatic set_rom(input int w0, input int w1, input int w2, input int w3,
                         input int w4, input int w5, input int w6, input int w7,
                         input int b0, input int b1, input int b2, input int b3);
    wrom[0] = 16'(w0); wrom[1] = 16'(w1); wrom[2] = 16'(w2); wrom[3] = 16'(w3);
    wrom[4] = 16'(w4); wrom[5] = 16'(w5); wrom[6] = 16'(w6); wrom[7] = 16'(w7);
    brom[0] = 16'(b0); brom[1] = 16'(b1); brom[2] = 16'(b2); brom[3] = 16'(b3);
  endtask

  task automatic send(input int x0, input int x1);
    bit   ok;
    logic was_ready;
    exp_t e;
    for (int m = 0; m < 4; m++) begin
      e.data = model(m, x0, x1);
      e.idx  = 2'(m);
      e.last = (m == 3);
      sb.push_back(e);
    end
    in_data  = {x1[15:0], x0[15:0]};
    in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      was_ready = in_ready;
      @(posedge clk); #1;
      if (was_ready === 1'b1) ok = 1'b1;
    end
    in_valid = 1'b0;
    cap_cyc  = cyc;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL capture_timeout: got in_ready low for 100 cycles, expected capture");
    end
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 300; k++) begin
      if (sb.size() == 0 && busy === 1'b0) break;
      @(posedge clk); #1;
    end
    vectors++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d outstanding busy %0b, expected 0 outstanding busy 0",
               name, sb.size(), busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
    vectors++; if (out_data !== 16'd0) begin miscompares++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    vectors++; if (out_idx !== 2'd0) begin miscompares++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
    vectors++; if (out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_last: got %0b expected 0", out_last); end
    vectors++; if (w_addr !== 3'd0) begin miscompares++; $display("FAIL reset_w_addr: got %0d expected 0", w_addr); end
    vectors++; if (b_addr !== 2'd0) begin miscompares++; $display("FAIL reset_b_addr: got %0d expected 0", b_addr); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    bit pend;
    bit done;
    int c0;
    set_rom(1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024, 512, 512, 512, 512);
    out_ready = 1'b1;
    hs_q.delete();
    send(1024, 2048);
    c0 = cap_cyc;
    pend = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      if (pend) begin
        done = 1'b1;
        vectors++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL nominal_in_ready_after_last: got in_ready %0b busy %0b, expected 1 and 0", in_ready, busy);
        end
      end
      pend = (out_valid === 1'b1 && out_ready === 1'b1 && out_last === 1'b1);
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL nominal_last_timeout: got no out_last handshake, expected one within 100 cycles");
    end
    vectors++;
    if (hs_q.size() != 4) begin
      miscompares++;
      $display("FAIL nominal_hs_count: got %0d handshakes expected 4", hs_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (hs_q[k] - c0 != 5 * (k + 1)) begin
          miscompares++;
          $display("FAIL nominal_hs_timing: neuron %0d got %0d cycles after capture, expected %0d",
                   k, hs_q[k] - c0, 5 * (k + 1));
        end
      end
    end
    drain("nominal");
  endtask

  task automatic test_relu();
    set_rom(-2048, 512, 1024, 1024, -1, 0, -1, 0, 0, -4096, 0, 2);
    out_ready = 1'b1;
    send(1024, 1024);
    drain("relu_a");
    send(1, 0);
    drain("relu_b");
  endtask

  task automatic test_saturation();
    set_rom(31744, 31744, 1057, 0, -31744, -31744, 0, 0, 0, 0, 0, 32767);
    out_ready = 1'b1;
    send(31744, 31744);
    drain("saturation");
  endtask

  task automatic test_backpressure();
    bit          ok;
    logic [15:0] d;
    logic [1:0]  i;
    logic [2:0]  wa;
    logic [1:0]  ba;
    set_rom(100, -200, 3000, 512, 2048, 2048, -1024, 4096, 10, -20, 30, 0);
    out_ready = 1'b0;
    send(5000, 700);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (out_valid === 1'b1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (out_valid === 1'b1 && out_idx === 2'd1) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_wait_n1: got no out_valid for neuron 1, expected one within 50 cycles");
    end
    d = out_data; i = out_idx; wa = w_addr; ba = b_addr;
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0] ? 1'b0 : 1'b1;
      in_data  = $urandom();
      @(posedge clk); #1;
      vectors++;
      if (out_valid !== 1'b1 || out_data !== d || out_idx !== i || w_addr !== wa || b_addr !== ba || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stall_hold: cycle %0d got v%0b d%0d i%0d wa%0d ba%0d rdy%0b, expected v1 d%0d i%0d wa%0d ba%0d rdy0",
                 k, out_valid, out_data, out_idx, w_addr, b_addr, in_ready, d, i, wa, ba);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    set_rom(100, -200, 3000, 512, 2048, 2048, -1024, 4096, 10, -20, 30, 0);
    out_ready = 1'b1;
    send(3000, 1500);
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 && out_idx === 2'd1) ok = 1'b1;
    end
    @(posedge clk); #1;
    vectors++;
    if (!ok || b_addr !== 2'd2 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_in_mac2: got found %0b b_addr %0d busy %0b, expected 1 2 1", ok, b_addr, busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vectors++;
    if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0 || w_addr !== 3'd0 || b_addr !== 2'd0) begin
      miscompares++;
      $display("FAIL rstmid_state: got busy %0b rdy %0b v %0b wa %0d ba %0d, expected 0 1 0 0 0",
               busy, in_ready, out_valid, w_addr, b_addr);
    end
    vectors++;
    if (sb.size() != 2) begin
      miscompares++;
      $display("FAIL rstmid_pending: got %0d unemitted results, expected 2", sb.size());
    end
    sb.delete();
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL rstmid_no_emit: got out_valid after reset, expected none");
    end
    send(1024, 2048);
    drain("reset_mid");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish after 400000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    set_rom(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_nominal();
    test_relu();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
